// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, stall, flush and bubble control.
// Optional performance counters are compiled in when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // the source holds valid and payload stable until that edge, and ready never
    // depends combinationally on valid of the same side.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              m_valid;
    logic              s_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    logic accept;
    logic emit;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign m_valid = (state != ST_EMPTY);
    assign s_valid = (state == ST_FULL);
    assign accept  = in_valid & in_ready;
    assign emit    = m_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !emit) begin
                        state_next = ST_FULL;
                    end else if (!accept && emit) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL:  if (emit) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Flush suppresses every load so the data registers keep their last contents.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state)
                ST_EMPTY: load_main_in = accept;
                ST_ONE: begin
                    load_main_in = accept & emit;
                    load_skid    = accept & ~emit;
                end
                ST_FULL:  load_main_skid = emit;
                default: begin
                    load_main_in   = 1'b0;
                    load_main_skid = 1'b0;
                    load_skid      = 1'b0;
                end
            endcase
        end
    end

    // Ready is a flop of the next occupancy, so backpressure never ripples combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (state_next != ST_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_ctrl <= CTRL_BUBBLE;
            m_data <= '0;
            s_ctrl <= CTRL_BUBBLE;
            s_data <= '0;
        end else begin
            if (load_main_in) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end else if (load_main_skid) begin
                m_ctrl <= s_ctrl;
                m_data <= s_data;
            end
            if (load_skid) begin
                s_ctrl <= in_ctrl;
                s_data <= in_data;
            end
        end
    end

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_BUBBLE;
    assign out_data  = m_data;

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (m_valid || s_valid || in_valid)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
